imm_encoder: RTL

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// Immediate encoder: packs a separate immediate into an RV32 instruction word
// through one encode stage and a small FIFO (4 entries total). Optional macro: IMM_RANGE_CHECK_EN.
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_base,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [7:0]  err_cnt,
  output logic [2:0]  level
);

  typedef enum logic [2:0] {
    FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_UNK
  } fmt_t;

  fmt_t        w_fmt;
  logic [31:0] w_enc_inst;
  logic        w_accept;
  logic        w_pop;

  always_comb begin
    w_fmt = FMT_UNK;
    case (in_base[6:0])
      7'b0010011: w_fmt = (in_base[13:12] == 2'b01) ? FMT_SH : FMT_I;
      7'b0000011,
      7'b1100111: w_fmt = FMT_I;
      7'b0100011: w_fmt = FMT_S;
      7'b1100011: w_fmt = FMT_B;
      7'b0110111,
      7'b0010111: w_fmt = FMT_U;
      7'b1101111: w_fmt = FMT_J;
      default:    w_fmt = FMT_UNK;
    endcase
  end

  always_comb begin
    w_enc_inst = in_base;
    case (w_fmt)
      FMT_I:  w_enc_inst[31:20] = in_imm[11:0];
      FMT_SH: w_enc_inst[24:20] = in_imm[4:0];
      FMT_S: begin
        w_enc_inst[31:25] = in_imm[11:5];
        w_enc_inst[11:7]  = in_imm[4:0];
      end
      FMT_B: begin
        w_enc_inst[31]    = in_imm[12];
        w_enc_inst[30:25] = in_imm[10:5];
        w_enc_inst[11:8]  = in_imm[4:1];
        w_enc_inst[7]     = in_imm[11];
      end
      FMT_U:  w_enc_inst[31:12] = in_imm[31:12];
      FMT_J: begin
        w_enc_inst[31]    = in_imm[20];
        w_enc_inst[30:21] = in_imm[10:1];
        w_enc_inst[20]    = in_imm[11];
        w_enc_inst[19:12] = in_imm[19:12];
      end
      default: w_enc_inst = in_base;
    endcase
  end

  logic        r_stg_v;
  logic [31:0] r_stg_inst;
  logic [31:0] r_mem_inst [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_cnt;
  logic [2:0]  r_level;

  // level counts the encode stage plus the FIFO, so a pop never frees a slot in the same cycle
  assign in_ready  = ~r_level[2];
  assign out_valid = (r_cnt != 3'd0);
  assign out_inst  = r_mem_inst[r_rd_ptr];
  assign level     = r_level;
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_v    <= 1'b0;
      r_stg_inst <= 32'd0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_cnt      <= 3'd0;
      r_level    <= 3'd0;
      for (int i = 0; i < 4; i++) r_mem_inst[i] <= 32'd0;
    end else if (flush) begin
      r_stg_v  <= 1'b0;
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_cnt    <= 3'd0;
      r_level  <= 3'd0;
    end else begin
      r_stg_v <= w_accept;
      if (w_accept) r_stg_inst <= w_enc_inst;
      // the stage always drains: with 4 total, the FIFO has room whenever the stage is full
      if (r_stg_v) begin
        r_mem_inst[r_wr_ptr] <= r_stg_inst;
        r_wr_ptr             <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      r_cnt   <= r_cnt + {2'b00, r_stg_v} - {2'b00, w_pop};
      r_level <= r_level + {2'b00, w_accept} - {2'b00, w_pop};
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic       w_enc_err;
  logic       w_fit12;
  logic       w_fit13;
  logic       w_fit21;
  logic       r_stg_err;
  logic [3:0] r_mem_err;
  logic [7:0] r_err_cnt;

  assign w_fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign w_fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign w_fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    w_enc_err = 1'b0;
    case (w_fmt)
      FMT_I, FMT_S: w_enc_err = ~w_fit12;
      FMT_SH:       w_enc_err = |in_imm[31:5];
      FMT_B:        w_enc_err = ~w_fit13 | in_imm[0];
      FMT_J:        w_enc_err = ~w_fit21 | in_imm[0];
      FMT_U:        w_enc_err = |in_imm[11:0];
      default:      w_enc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_err <= 1'b0;
      r_mem_err <= 4'd0;
      r_err_cnt <= 8'd0;
    end else if (!flush) begin
      if (w_accept) r_stg_err <= w_enc_err;
      if (r_stg_v) r_mem_err[r_wr_ptr] <= r_stg_err;
      if (w_pop && r_mem_err[r_rd_ptr] && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign out_err = r_mem_err[r_rd_ptr];
  assign err_cnt = r_err_cnt;
`else
  assign out_err = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule
